// File: rtl/fact_pkg.sv
// fact_pkg: shared widths, exact-result limit and FSM state type for the factorial engine.
package fact_pkg;
    localparam int DATA_W = 32;
    // Largest n whose factorial still fits in DATA_W bits.
    localparam int MAX_EXACT_N = 12;
    typedef enum logic [1:0] {IDLE, MUL, DONE} fact_state_t;
endpackage

// File: rtl/multiplier.sv
// multiplier: 32x32 combinational multiply, product truncated to 32 bits.
module multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out
);
    assign out = a * b;
endmodule

// File: rtl/factorial_ctrl.sv
// factorial_ctrl: computes n! mod 2^32 with one multiply per clock over valid/ready channels.
// Define FACT_OVF_EN to add the ovf output flagging n beyond the exact range.
module factorial_ctrl
    import fact_pkg::*;
#(
    parameter int N_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_W-1:0]    in_n,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              busy
`ifdef FACT_OVF_EN
    ,
    output logic              ovf
`endif
);
    fact_state_t       state;
    logic [N_W-1:0]    cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] prod;

    multiplier u_mul (
        .a  (acc),
        .b  ({{(DATA_W-N_W){1'b0}}, cnt}),
        .out(prod)
    );

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= DATA_W'(1);
            out_result <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    cnt   <= in_n;
                    acc   <= DATA_W'(1);
                    state <= MUL;
                end
                MUL: if (cnt <= N_W'(1)) begin
                    out_result <= acc;
                    state      <= DONE;
                end else begin
                    acc <= prod;
                    cnt <= cnt - 1'b1;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FACT_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (state == IDLE && in_valid)
            ovf <= in_n > N_W'(MAX_EXACT_N);
    end
`endif
endmodule

// File: tb/tb_factorial_ctrl.sv
// tb_factorial_ctrl: directed and randomized checks of factorial_ctrl against an arithmetic model.
// ovf checks are active when FACT_OVF_EN is defined.
module tb_factorial_ctrl;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        out_ready = 0;
    logic [7:0]  in_n = 0;
    logic        in_ready, out_valid, busy;
    logic [31:0] out_result;
`ifdef FACT_OVF_EN
    logic        ovf;
`endif
    int checks = 0;
    int errors = 0;

    factorial_ctrl #(.N_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .busy(busy)
`ifdef FACT_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fact(int n);
        logic [31:0] r = 1;
        for (int i = 2; i <= n; i++) r = r * 32'(i);
        return r;
    endfunction

    task automatic run_req(input int n, input bit consume, output logic [31:0] res,
                           output int lat, output bit busy_ok, output logic ovf_v);
        int w = 0;
        busy_ok = 1;
        lat = 0;
        ovf_v = 0;
        while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
        in_valid = 1;
        in_n = 8'(n);
        @(posedge clk); #1;
        in_valid = 0;
        while (!out_valid && lat < 300) begin
            if (!busy) busy_ok = 0;
            @(posedge clk); #1;
            lat++;
        end
        if (!busy) busy_ok = 0;
        res = out_result;
`ifdef FACT_OVF_EN
        ovf_v = ovf;
`endif
        if (consume) begin
            out_ready = 1;
            @(posedge clk); #1;
            out_ready = 0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %0b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %0b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %0b exp 0", busy); end
        checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL reset out_result got %0d exp 0", out_result); end
`ifdef FACT_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset ovf got %0b exp 0", ovf); end
`endif
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int          ns[6] = '{5, 0, 1, 12, 13, 34};
        logic [31:0] exp[6] = '{32'd120, 32'd1, 32'd1, 32'd479001600, 32'd1932053504, 32'd0};
        logic [31:0] res;
        int          lat;
        bit          bok;
        logic        ov;
        for (int i = 0; i < 6; i++) begin
            run_req(ns[i], 1, res, lat, bok, ov);
            checks++; if (res !== exp[i]) begin errors++; $display("FAIL directed n=%0d result got %0d exp %0d", ns[i], res, exp[i]); end
            checks++; if (lat != (ns[i] < 1 ? 1 : ns[i])) begin errors++; $display("FAIL directed n=%0d latency got %0d exp %0d", ns[i], lat, ns[i] < 1 ? 1 : ns[i]); end
            checks++; if (!bok) begin errors++; $display("FAIL directed n=%0d busy got 0 exp 1", ns[i]); end
`ifdef FACT_OVF_EN
            checks++; if (ov !== (ns[i] > 12)) begin errors++; $display("FAIL directed n=%0d ovf got %0b exp %0b", ns[i], ov, ns[i] > 12); end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        int          lat;
        bit          bok;
        logic        ov;
        run_req(4, 0, res, lat, bok, ov);
        checks++; if (res !== 32'd24) begin errors++; $display("FAIL bp result got %0d exp 24", res); end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin in_valid = 1; in_n = 7; end
            @(posedge clk); #1;
            in_valid = 0;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp hold out_valid cyc %0d got %0b exp 1", i, out_valid); end
            checks++; if (out_result !== 32'd24) begin errors++; $display("FAIL bp hold result cyc %0d got %0d exp 24", i, out_result); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp hold in_ready cyc %0d got %0b exp 0", i, in_ready); end
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp release in_ready got %0b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp release out_valid got %0b exp 0", out_valid); end
        checks++; if (out_result !== 32'd24) begin errors++; $display("FAIL bp idle result got %0d exp 24", out_result); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp ignored req busy got %0b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        int          cyc = 0;
        int          acc_c[$];
        int          val_c[$];
        logic [31:0] res_q[$];
        bit          rdy;
        out_ready = 1;
        in_n = 3;
        in_valid = 1;
        while (res_q.size() < 2 && cyc < 100) begin
            rdy = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (rdy && in_valid) begin acc_c.push_back(cyc); in_n = 6; end
            if (out_valid) begin val_c.push_back(cyc); res_q.push_back(out_result); end
        end
        in_valid = 0;
        @(posedge clk); #1;
        out_ready = 0;
        checks++; if (res_q.size() != 2 || acc_c.size() != 2) begin
            errors++; $display("FAIL b2b counts results %0d accepts %0d exp 2 2", res_q.size(), acc_c.size());
        end else begin
            checks++; if (res_q[0] !== 32'd6) begin errors++; $display("FAIL b2b first result got %0d exp 6", res_q[0]); end
            checks++; if (res_q[1] !== 32'd720) begin errors++; $display("FAIL b2b second result got %0d exp 720", res_q[1]); end
            checks++; if (val_c[0] - acc_c[0] != 3) begin errors++; $display("FAIL b2b first latency got %0d exp 3", val_c[0] - acc_c[0]); end
            checks++; if (acc_c[1] - val_c[0] != 2) begin errors++; $display("FAIL b2b reaccept gap got %0d exp 2", acc_c[1] - val_c[0]); end
            checks++; if (val_c[1] - acc_c[1] != 6) begin errors++; $display("FAIL b2b second latency got %0d exp 6", val_c[1] - acc_c[1]); end
        end
    endtask

    task automatic test_reset_mid();
        bit          saw = 0;
        logic [31:0] res;
        int          lat;
        bit          bok;
        logic        ov;
        in_valid = 1;
        in_n = 10;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) begin @(posedge clk); #1; if (out_valid) saw = 1; end
        #2;
        rst_n = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst in_ready got %0b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst out_valid got %0b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy got %0b exp 0", busy); end
        checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL midrst out_result got %0d exp 0", out_result); end
`ifdef FACT_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrst ovf got %0b exp 0", ovf); end
`endif
        repeat (2) begin @(posedge clk); #1; if (out_valid) saw = 1; end
        rst_n = 1;
        repeat (12) begin @(posedge clk); #1; if (out_valid) saw = 1; end
        checks++; if (saw) begin errors++; $display("FAIL midrst out_valid pulse got 1 exp 0"); end
        run_req(3, 1, res, lat, bok, ov);
        checks++; if (res !== 32'd6) begin errors++; $display("FAIL midrst after result got %0d exp 6", res); end
    endtask

    task automatic test_random();
        logic [31:0] res;
        int          lat;
        bit          bok;
        logic        ov;
        int          n;
        for (int i = 0; i < 20; i++) begin
            n = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
            run_req(n, 1, res, lat, bok, ov);
            checks++; if (res !== fact(n)) begin errors++; $display("FAIL random n=%0d result got %0d exp %0d", n, res, fact(n)); end
            checks++; if (lat != (n < 1 ? 1 : n)) begin errors++; $display("FAIL random n=%0d latency got %0d exp %0d", n, lat, n < 1 ? 1 : n); end
`ifdef FACT_OVF_EN
            checks++; if (ov !== (n > 12)) begin errors++; $display("FAIL random n=%0d ovf got %0b exp %0b", n, ov, n > 12); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/factorial_ctrl.md
Name: factorial_ctrl

Overview:
- Sequential controller that computes n! by iterating the existing 32-bit combinational `multiplier` datapath, one multiply per clock.
- Takes n over a valid/ready request channel and returns the 32-bit result over a valid/ready response channel.
- It is the top-level compute engine of the factorial design. The multiplier is instantiated inside it and used by no other block.

Parameters:
- N_W, 8, width of the n operand; n range 0..2^N_W-1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_n  input  N_W  operand n
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_result  output  32  n! mod 2^32
- busy  output  1  high in MUL and DONE
- ovf  output  1  present only with FACT_OVF_EN; see Optional Feature

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, busy=0, ovf=0, internal acc=1, cnt=0.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. On in_valid: cnt<=in_n, acc<=1, go to MUL.
  - MUL: if cnt<=1, go to DONE and latch out_result<=acc. Else acc<=acc*cnt and cnt<=cnt-1.
  - DONE: out_valid=1. On out_ready: go to IDLE and out_valid<=0.
- Multiplier hookup: a=acc, b=cnt zero-extended to 32 bits, product=out.
- Width rule: the product is truncated to 32 bits, so the result is n! mod 2^32. For n>=34 the result is 0.
- Latency: out_valid rises exactly max(n,1) rising edges after the accepting edge. Examples: n=0 takes 1, n=1 takes 1, n=5 takes 5.
- in_ready is low in MUL and DONE; in_valid and in_n are ignored there.
- There is no same-cycle accept on the DONE->IDLE edge; in_ready reasserts the cycle after the result is consumed.
- out_result is held stable while out_valid && !out_ready. It keeps its last value in IDLE until the next DONE overwrites it.
- in_n is sampled only at accept; later changes have no effect.
- Reset asserted mid-operation immediately aborts: all outputs return to reset values and no partial result is emitted.

Optional Feature:
- Macro: FACT_OVF_EN.
- Defined:
  - Adds the ovf output port.
  - ovf is registered at accept as (in_n > MAX_EXACT_N) and held alongside out_result through DONE.
  - ovf clears on reset only. It is overwritten at the next accept.
- Undefined: no ovf port and no associated logic. Otherwise behaviour is identical.

Decomposition:
- Package fact_pkg:
  - DATA_W=32.
  - MAX_EXACT_N=12 (largest n with n! < 2^32).
  - typedef enum logic [1:0] {IDLE, MUL, DONE} fact_state_t.
- Sub-module: the existing `multiplier` (32x32->32), instantiated once as u_mul. No new sub-module.

Test Plan:
- n=5 accepted -> out_valid after exactly 5 edges, out_result=120, busy high in between.
- n=0, then n=1 -> each gives out_result=1 after 1 edge. With FACT_OVF_EN, ovf=0.
- n=12 -> out_result=479001600, ovf=0. n=13 -> out_result=1932053504, ovf=1. n=34 -> out_result=0.
- Backpressure on n=4: hold out_ready=0 for 10 cycles.
  - out_result=24 and out_valid=1 stay stable; in_ready stays 0.
  - A pulse of in_valid with in_n=7 during the hold is ignored.
  - After release, in_ready=1 on the following cycle.
- Back-to-back: in_valid held high with n=3 then n=6, out_ready tied 1 -> results 6 then 720, with one idle cycle between consume and the next accept.
- Reset: assert rst_n=0 on the 4th MUL cycle of n=10.
  - All outputs go to reset values asynchronously; no out_valid pulse.
  - After release, n=3 -> 6.
